nk_game_core: RTL and testbench

- Parametrised successor to the fixed 3x3 tic-tac-toe board/controller/win-declarer group.
- Holds an N x N board for two sides, player (1) and CPU (2), and arbitrates turns.
- Handles player and CPU moves over valid/ready handshakes.
- After every move, checks K-in-a-row through the last-placed cell in a fixed 4-cycle check, then declares win, draw or next turn.
- Board output feeds the existing display and AI path; the AI drives the cpu_* handshake.

---
 rtl/nk_game_pkg.sv | 12 +
 rtl/nk_line_count.sv | 42 ++++
 rtl/nk_game_core.sv | 101 ++++++++++
 tb/tb_nk_game_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nk_game_pkg.sv
// nk_game_pkg: cell, state and direction encodings shared by the game core
package nk_game_pkg;
  localparam logic [1:0] C_EMPTY = 2'b00, C_PLAYER = 2'b01, C_CPU = 2'b10;
  localparam logic [2:0] S_IDLE = 3'd0, S_P_TURN = 3'd1, S_C_TURN = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4, S_CLEAR = 3'd5;
  localparam logic [1:0] D_H = 2'd0, D_V = 2'd1, D_D = 2'd2, D_A = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/nk_line_count.sv
// nk_line_count: run length of one side through last_idx along one direction
module nk_line_count
  import nk_game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int IDX_W = clog2(N*N),
  localparam int CW = clog2(2*K)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [IDX_W-1:0] last_idx,
  input  logic [1:0]       side,
  input  logic [1:0]       dir,
  output logic [CW-1:0]    len
);
  localparam int BW = clog2(2*N*N);
  int row, col, dr, dc, sg, r, c, p;
  logic run;
  always_comb begin
    row = int'(last_idx) / N;
    col = int'(last_idx) % N;
    dr = (dir == D_H) ? 0 : 1;
    dc = (dir == D_V) ? 0 : (dir == D_A) ? -1 : 1;
    len = CW'(1);
    sg = 1;
    r = 0;
    c = 0;
    p = 0;
    run = 1'b0;
    for (int g = 0; g < 2; g++) begin
      sg = g ? -1 : 1;
      run = 1'b1;
      for (int s = 1; s < K; s++) begin
        r = row + sg * s * dr;
        c = col + sg * s * dc;
        p = (r >= 0 && r < N && c >= 0 && c < N) ? r * N + c : 0;
        run = run && r >= 0 && r < N && c >= 0 && c < N && board[BW'(2*p) +: 2] == side;
        len = len + CW'(run);
      end
    end
  end
endmodule

// File: rtl/nk_game_core.sv
// nk_game_core: N x N board, turn arbiter and K-in-a-row win/draw judge
module nk_game_core
  import nk_game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int IDX_W = clog2(N*N),
  localparam int TRN_W = clog2(N*N+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               start,
  input  logic               mv_valid,
  input  logic [IDX_W-1:0]   mv_idx,
  output logic               mv_ready,
  output logic               cpu_req,
  input  logic               cpu_valid,
  input  logic [IDX_W-1:0]   cpu_idx,
  output logic [2*N*N-1:0]   board,
  output logic [TRN_W-1:0]   turns,
  output logic               illegal,
  output logic               player_win,
  output logic               cpu_win,
  output logic               draw,
  output logic [2:0]         st
);
  localparam int BW = clog2(2*N*N);
  localparam int CW = clog2(2*K);
  logic [IDX_W-1:0] last_idx, idx;
  logic [1:0] side, code, ck;
  logic [CW-1:0] len;
  logic win, hit, take, legal;
  int p;
  assign mv_ready = st == S_P_TURN;
  assign cpu_req = st == S_C_TURN;
  always_comb begin
    idx = mv_ready ? mv_idx : cpu_idx;
    code = mv_ready ? C_PLAYER : C_CPU;
    take = (mv_ready && mv_valid) || (cpu_req && cpu_valid);
    p = (int'(idx) < N*N) ? int'(idx) : 0;
    legal = int'(idx) < N*N && board[BW'(2*p) +: 2] == C_EMPTY;
    hit = int'(len) >= K;
  end
  // one direction per CHECK cycle, selected by the check counter
  nk_line_count #(.N(N), .K(K)) u_line (
    .board(board), .last_idx(last_idx), .side(side), .dir(ck), .len(len)
  );
  always_ff @(posedge clk)
    if (rst) begin
      board <= '0;
      turns <= '0;
      illegal <= 1'b0;
      player_win <= 1'b0;
      cpu_win <= 1'b0;
      draw <= 1'b0;
      st <= S_IDLE;
      last_idx <= '0;
      side <= C_EMPTY;
      ck <= '0;
      win <= 1'b0;
    end else begin
      illegal <= take && !legal;
      case (st)
        S_IDLE: if (start) st <= mode ? S_C_TURN : S_P_TURN;
        S_P_TURN, S_C_TURN: if (take && legal) begin
          board[BW'(2*p) +: 2] <= code;
          turns <= turns + TRN_W'(1);
          last_idx <= idx;
          side <= code;
          ck <= D_H;
          win <= 1'b0;
          st <= S_CHECK;
        end
        S_CHECK: begin
          ck <= ck + 2'd1;
          win <= win || hit;
          if (ck == D_A) begin
            if (win || hit) begin
              player_win <= side == C_PLAYER;
              cpu_win <= side == C_CPU;
              st <= S_DONE;
            end else if (turns == TRN_W'(N*N)) begin
              draw <= 1'b1;
              st <= S_DONE;
            end else st <= (side == C_PLAYER) ? S_C_TURN : S_P_TURN;
          end
        end
        S_DONE: if (start) st <= S_CLEAR;
        S_CLEAR: begin
          board <= '0;
          turns <= '0;
          player_win <= 1'b0;
          cpu_win <= 1'b0;
          draw <= 1'b0;
          st <= mode ? S_C_TURN : S_P_TURN;
        end
        default: st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_nk_game_core.sv
// tb_nk_game_core: scoreboard bench driving a 3x3/K3 core and a 5x5/K4 core
module tb_nk_game_core;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mode = '0, start = '0, mvv = '0, cv = '0;
  logic [1:0][4:0] mvi = '0, ci = '0;
  wire [1:0] mvr, creq, ill, pw, cw, drw;
  wire [1:0][2:0] st;
  wire [1:0][4:0] trn;
  wire [1:0][49:0] brd;
  assign trn[0][4] = 1'b0;
  assign brd[0][49:18] = '0;
  always #5 clk = ~clk;

  nk_game_core #(.N(3), .K(3)) d3 (
    .clk(clk), .rst(rst), .mode(mode[0]), .start(start[0]), .mv_valid(mvv[0]), .mv_idx(mvi[0][3:0]),
    .mv_ready(mvr[0]), .cpu_req(creq[0]), .cpu_valid(cv[0]), .cpu_idx(ci[0][3:0]), .board(brd[0][17:0]),
    .turns(trn[0][3:0]), .illegal(ill[0]), .player_win(pw[0]), .cpu_win(cw[0]), .draw(drw[0]), .st(st[0])
  );
  nk_game_core #(.N(5), .K(4)) d5 (
    .clk(clk), .rst(rst), .mode(mode[1]), .start(start[1]), .mv_valid(mvv[1]), .mv_idx(mvi[1]),
    .mv_ready(mvr[1]), .cpu_req(creq[1]), .cpu_valid(cv[1]), .cpu_idx(ci[1]), .board(brd[1]),
    .turns(trn[1]), .illegal(ill[1]), .player_win(pw[1]), .cpu_win(cw[1]), .draw(drw[1]), .st(st[1])
  );

  typedef struct {
    int kind;
    logic [49:0] b;
    int t;
    int s;
    bit p;
    bit c;
    bit d;
  } exp_t;
  exp_t q[2][$];
  exp_t me;
  int mb[2][25];
  int mt[2], ms[2];
  int DR[4] = '{0, 1, 1, 1};
  int DC[4] = '{1, 0, 1, -1};
  int nchk = 0, npass = 0;
  int cnt[2];
  bit pend[2];
  logic [2:0] pst[2];
  int s1[5] = '{0, 3, 1, 4, 2};
  int s2[11] = '{0, 4, 4, 9, 2, 1, 7, 6, 3, 5, 8};
  int s3[9] = '{0, 1, 2, 3, 5, 4, 7, 6, 8};
  int s4[7] = '{3, 0, 7, 1, 11, 2, 15};
  int s5[7] = '{4, 20, 5, 21, 6, 22, 7};

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endfunction

  function automatic int sz(int u); return u ? 5 : 3; endfunction
  function automatic int kk(int u); return u ? 4 : 3; endfunction
  function automatic int nn(int u); return sz(u) * sz(u); endfunction

  function automatic logic [49:0] pk(int u);
    logic [49:0] b;
    b = '0;
    for (int i = 0; i < nn(u); i++) b[2*i +: 2] = mb[u][i][1:0];
    return b;
  endfunction

  // any K-long window of side s anywhere on the board
  function automatic bit wins(int u, int s);
    int n, k, rr, cc;
    bit ok;
    n = sz(u);
    k = kk(u);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1;
          for (int j = 0; j < k; j++) begin
            rr = r + j * DR[d];
            cc = c + j * DC[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 0;
            else if (mb[u][rr*n+cc] != s) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model(int u);
    for (int i = 0; i < 25; i++) mb[u][i] = 0;
    mt[u] = 0;
  endtask

  task automatic new_game(int u, bit m);
    bit was_done;
    was_done = ms[u] == 4;
    mode[u] = m;
    start[u] = 1'b1;
    tick;
    start[u] = 1'b0;
    if (was_done) begin
      chk("clear_st", st[u], 5);
      tick;
    end
    chk("go_st", st[u], m ? 2 : 1);
    chk("go_board", brd[u], 0);
    chk("go_turns", trn[u], 0);
    chk("go_flags", {pw[u], cw[u], drw[u]}, 0);
    clear_model(u);
    ms[u] = m ? 2 : 1;
  endtask

  task automatic mv(int u, int idx, bit other);
    int s, n;
    bit ok, w;
    exp_t e;
    s = ms[u];
    n = 0;
    while (!(s == 1 ? mvr[u] : creq[u]) && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) begin
      chk("ready_timeout", {mvr[u], creq[u]}, {s == 1, s == 2});
      return;
    end
    if (s == 1) begin
      mvv[u] = 1'b1;
      mvi[u] = idx[4:0];
      cv[u] = other;
      ci[u] = 5'($urandom_range(0, 31));
    end else begin
      cv[u] = 1'b1;
      ci[u] = idx[4:0];
      mvv[u] = other;
      mvi[u] = 5'($urandom_range(0, 31));
    end
    start[u] = 1'($urandom_range(0, 1));
    ok = idx < nn(u) && mb[u][idx] == 0;
    if (!ok) e = '{0, pk(u), mt[u], ms[u], 1'b0, 1'b0, 1'b0};
    else begin
      mb[u][idx] = s;
      mt[u]++;
      w = wins(u, s);
      ms[u] = (w || mt[u] == nn(u)) ? 4 : 3 - s;
      e = '{1, pk(u), mt[u], ms[u], w && s == 1, w && s == 2, !w && mt[u] == nn(u)};
    end
    q[u].push_back(e);
    tick;
    mvv[u] = 1'b0;
    cv[u] = 1'b0;
    start[u] = 1'b0;
    n = 0;
    while (q[u].size() != 0 && n < 20) begin
      tick;
      n++;
    end
    chk("settle", q[u].size(), 0);
    if (!ok) chk("ready_hold", {mvr[u], creq[u]}, {s == 1, s == 2});
  endtask

  always @(negedge clk)
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        pend[u] = 0;
        cnt[u] = 0;
        pst[u] = 3'd0;
      end else begin
        if (pend[u]) cnt[u] = 1;
        else if (cnt[u] > 0) cnt[u]++;
        if (ill[u]) begin
          chk("ill_expected", q[u].size() > 0 && q[u][0].kind == 0, 1);
          if (q[u].size() > 0 && q[u][0].kind == 0) begin
            me = q[u].pop_front();
            chk("ill_board", brd[u], me.b);
            chk("ill_turns", trn[u], me.t);
            chk("ill_st", st[u], me.s);
          end
        end
        if (pst[u] == 3'd3 && st[u] != 3'd3) begin
          chk("res_expected", q[u].size() > 0 && q[u][0].kind == 1, 1);
          if (q[u].size() > 0 && q[u][0].kind == 1) begin
            me = q[u].pop_front();
            chk("res_st", st[u], me.s);
            chk("res_board", brd[u], me.b);
            chk("res_turns", trn[u], me.t);
            chk("res_flags", {pw[u], cw[u], drw[u]}, {me.p, me.c, me.d});
            chk("res_latency", cnt[u], 5);
          end
        end
        pend[u] = (mvr[u] && mvv[u]) || (creq[u] && cv[u]);
        pst[u] = st[u];
      end
    end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u, n, idx;
    int em[$];
    for (int i = 0; i < 2; i++) begin
      clear_model(i);
      ms[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_st", st[i], 0);
      chk("rst_board", brd[i], 0);
      chk("rst_turns", trn[i], 0);
      chk("rst_flags", {ill[i], pw[i], cw[i], drw[i]}, 0);
      chk("rst_hs", {mvr[i], creq[i]}, 0);
    end
    new_game(0, 1'b0);
    foreach (s1[i]) mv(0, s1[i], 1'b0);
    chk("p_win", {pw[0], cw[0], drw[0]}, 3'b100);
    chk("p_win_st", st[0], 4);
    chk("p_win_turns", trn[0], 5);
    repeat (4) begin
      tick;
      chk("done_no_req", {creq[0], mvr[0]}, 0);
    end
    new_game(0, 1'b0);
    foreach (s2[i]) mv(0, s2[i], 1'b0);
    chk("draw", {pw[0], cw[0], drw[0]}, 3'b001);
    new_game(0, 1'b0);
    foreach (s3[i]) mv(0, s3[i], 1'b0);
    chk("last_cell_win", {pw[0], cw[0], drw[0]}, 3'b100);
    new_game(1, 1'b1);
    foreach (s4[i]) mv(1, s4[i], 1'b0);
    chk("anti_diag_win", {pw[1], cw[1], drw[1]}, 3'b010);
    new_game(1, 1'b1);
    chk("clear_req", creq[1], 1);
    foreach (s5[i]) mv(1, s5[i], 1'b0);
    chk("no_wrap_win", {pw[1], cw[1], drw[1]}, 3'b000);
    chk("no_wrap_st", st[1], 1);
    new_game(0, 1'b0);
    mvv[0] = 1'b1;
    mvi[0] = 5'd4;
    tick;
    mvv[0] = 1'b0;
    chk("in_check", st[0], 3);
    tick;
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    tick;
    rst = 1'b0;
    chk("midrst_st", st[0], 0);
    chk("midrst_board", brd[0], 0);
    chk("midrst_turns", trn[0], 0);
    chk("midrst_flags", {ill[0], pw[0], cw[0], drw[0]}, 0);
    chk("midrst_st1", st[1], 0);
    for (int i = 0; i < 2; i++) begin
      clear_model(i);
      ms[i] = 0;
    end
    for (int g = 0; g < 12; g++) begin
      u = g % 2;
      new_game(u, 1'($urandom_range(0, 1)));
      n = 0;
      while (ms[u] != 4 && n < 80) begin
        em.delete();
        for (int i = 0; i < nn(u); i++) if (mb[u][i] == 0) em.push_back(i);
        if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, u ? 31 : 15);
        else idx = em[$urandom_range(0, em.size() - 1)];
        mv(u, idx, 1'($urandom_range(0, 1)));
        n++;
      end
    end
    chk("q0_drained", q[0].size(), 0);
    chk("q1_drained", q[1].size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
